// File: rtl/cla_wide_add_seq.sv
// Wide add/subtract sequencer: one 7-bit carry-lookahead slice is reused across
// WORDS cycles, LSB slice first, with the inter-slice carry held in a register.

module cla_adder #(
    parameter int N = 7
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    logic [N-1:0] g, p;
    logic [N:0]   c;
    logic         pp;

    // Each carry is a flat sum of generate terms gated by the propagate
    // product of the bits above them, so no carry waits on another.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        pp   = 1'b0;
        for (int i = 0; i < N; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & ci);
        end
        s  = p ^ c[N-1:0];
        co = c[N];
    end
endmodule

module cla_wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7*WORDS-1:0]   op_a,
    input  logic [7*WORDS-1:0]   op_b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);
    localparam int SLICE = 7;
    localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [WORDS-1:0][SLICE-1:0] a;
        logic [WORDS-1:0][SLICE-1:0] b;
    } opnd_t;

    state_t                      state_q, state_d;
    opnd_t                       opnd_q, opnd_d;
    logic [IDXW-1:0]             idx_q, idx_d;
    logic                        carry_q, carry_d;
    logic [WORDS-1:0][SLICE-1:0] sum_q, sum_d;
    logic                        cout_q, cout_d;
    logic                        ovf_q, ovf_d;

    logic [SLICE-1:0] slice_s;
    logic             slice_co;
    logic             last;

    cla_adder #(.N(SLICE)) u_slice (
        .a  (opnd_q.a[idx_q]),
        .b  (opnd_q.b[idx_q]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    assign last = (idx_q == IDXW'(WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction folds into addition: invert B and force carry-in.
                    opnd_d.a = op_a;
                    opnd_d.b = sub ? ~op_b : op_b;
                    carry_d  = sub | cin;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = slice_s;
                carry_d      = slice_co;
                if (last) begin
                    idx_d   = '0;
                    cout_d  = slice_co;
                    ovf_d   = (opnd_q.a[WORDS-1][SLICE-1] == opnd_q.b[WORDS-1][SLICE-1]) &&
                              (slice_s[SLICE-1] != opnd_q.a[WORDS-1][SLICE-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        sum       = sum_q;
        cout      = cout_q;
        ovf       = ovf_q;
    end
endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Directed scoreboard bench for cla_wide_add_seq at WORDS=4 (28-bit operands).

module tb_cla_wide_add_seq;
    localparam int WORDS = 4;
    localparam int W     = 7 * WORDS;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] op_a, op_b;
    logic         cin, sub;
    logic         out_valid, out_ready;
    logic [W-1:0] sum;
    logic         cout, ovf, busy;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t hold;

    always #5 clk = ~clk;

    cla_wide_add_seq #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic ci, logic sb_);
        logic [W:0]   full;
        logic [W-1:0] bb;
        exp_t         e;
        bb     = sb_ ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sb_ ? 1'b1 : ci)};
        e.s    = full[W-1:0];
        e.c    = full[W];
        e.v    = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands while IDLE; the accept edge is the next rising edge.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic s);
        in_valid = 1'b1; op_a = a; op_b = b; cin = ci; sub = s;
        @(posedge clk); #1;
        sb.push_back(model(a, b, ci, s));
        in_valid = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_in_ready", 64'(in_ready), 64'd0);
    endtask

    // Count edges from accept to out_valid, then compare against the scoreboard head.
    task automatic wait_and_compare(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(WORDS));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            hold = e;
            check({tag, "_sum"}, 64'(sum), 64'(e.s));
            check({tag, "_cout"}, 64'(cout), 64'(e.c));
            check({tag, "_ovf"}, 64'(ovf), 64'(e.v));
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic s);
        accept(a, b, ci, s);
        wait_and_compare(tag);
        release_out(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout_ovf", 64'({cout, ovf}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_op("t1_boundary", 28'h000007F, 28'h0000001, 1'b0, 1'b0);
        check("t1_sum_const", 64'(hold.s), 64'h80);
        run_op("t2_ripple", 28'hFFFFFFF, 28'h0000001, 1'b0, 1'b0);
        check("t2_cout_const", 64'(hold.c), 64'd1);
        run_op("t2_ripple_cin", 28'hFFFFFFF, 28'h0000000, 1'b1, 1'b0);
        run_op("t3_sub_neg", 28'h0000005, 28'h0000007, 1'b1, 1'b1);
        check("t3_sum_const", 64'(hold.s), 64'hFFFFFFE);
        run_op("t3_sub_pos", 28'h0000007, 28'h0000005, 1'b0, 1'b1);
        run_op("t4_ovf", 28'h7FFFFFF, 28'h0000001, 1'b0, 1'b0);
        check("t4_ovf_const", 64'(hold.v), 64'd1);
        run_op("t4_ovf_neg", 28'h8000000, 28'h0000001, 1'b0, 1'b1);
        run_op("mixed", 28'h5A5A5A5, 28'h3C3C3C3, 1'b1, 1'b0);

        // Backpressure: result must hold and new operands must be ignored.
        accept(28'h1234567, 28'h0FEDCBA, 1'b0, 1'b0);
        wait_and_compare("t5");
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            check("t5_hold_sum", 64'(sum), 64'(hold.s));
            check("t5_hold_flags", 64'({cout, ovf}), 64'({hold.c, hold.v}));
            check("t5_hold_valid_ready", 64'({out_valid, in_ready}), 64'b10);
        end
        in_valid = 1'b1; op_a = 28'h0000100; op_b = 28'h0000023; cin = 1'b1; sub = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t5_idle_edge", 64'({out_valid, in_ready, busy}), 64'b010);
        @(posedge clk); #1;
        sb.push_back(model(28'h0000100, 28'h0000023, 1'b1, 1'b0));
        in_valid = 1'b0;
        check("t5_next_accept", 64'({in_ready, busy}), 64'b01);
        wait_and_compare("t5_next");
        release_out("t5_next");

        // Reset while idx=2: result is discarded.
        accept(28'h0ABCDEF, 28'h0111111, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t6_pre_sum_nonzero", 64'(sum != 0), 64'd1);
        rst = 1'b1; #1;
        void'(sb.pop_front());
        check("t6_ov", 64'(out_valid), 64'd0);
        check("t6_sum", 64'(sum), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        check("t6_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        run_op("t6_after", 28'h0000040, 28'h000003F, 1'b1, 1'b0);
        check("t6_sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cla_wide_add_seq.md
Name: cla_wide_add_seq

Overview:
Multi-cycle sequencer that performs WORDS*7-bit add/subtract by time-multiplexing a single 7-bit cla_adder slice, one slice per cycle, LSB slice first. It holds the carry between slices in a register and assembles the result in an output register. It presents valid/ready handshakes on both operand and result sides. It sits between wide-operand producers and consumers wherever a full-width adder is too costly in area.

Parameters:
WORDS, 4, number of 7-bit slices; operand width W = 7*WORDS (min 1).
SLICE (localparam), 7, slice width, fixed to the cla_adder width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
in_valid  in  1  operand request.
in_ready  out  1  sequencer can accept operands.
op_a  in  W  operand A.
op_b  in  W  operand B.
cin  in  1  carry-in; ignored when sub=1.
sub  in  1  1: compute A + ~B + 1; 0: compute A + B + cin.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts result.
sum  out  W  result.
cout  out  1  carry out of MSB (for sub: 1 = no borrow).
ovf  out  1  two's-complement signed overflow.
busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, any state): state=IDLE, slice index=0, carry reg=0, operand regs=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0. in_ready=1 once state is IDLE.
- States:
  - IDLE: in_ready=1. On in_valid (accept edge T):
    - latch op_a.
    - latch op_b, or ~op_b if sub=1.
    - carry = sub ? 1 : cin.
    - idx=0.
    - go RUN.
  - RUN: in_ready=0. Each cycle the cla_adder gets slice idx of A, slice idx of B', and the carry reg. On the edge:
    - sum[idx*7 +: 7] <= adder s.
    - carry <= adder cout.
    - idx <= idx+1.
    - When idx==WORDS-1: cout <= adder cout; ovf <= (A[W-1]==B'[W-1]) && (s[6]!=A[W-1]); go DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready go IDLE; out_valid drops on that edge.
- Handshakes: transfer occurs when valid&&ready are both high at a rising edge. Input fields are sampled only at the accept edge; later changes have no effect.
- Latency: out_valid rises on edge T+WORDS. Back-to-back throughput is one op per WORDS+2 cycles; DONE→IDLE and the next accept take separate edges. No overlap.
- sum, cout and ovf are valid only while out_valid=1. They stay stable throughout DONE regardless of how long out_ready stays low. sum slices update progressively during RUN.
- in_valid during RUN or DONE is ignored; no queuing.
- idx is sized ceil(log2(WORDS)), min 1 bit. It never exceeds WORDS-1.
- Reset mid-RUN or mid-DONE aborts the op. No partial result is presented; outputs go to reset values.
- WORDS=1: RUN lasts exactly one cycle.

Test Plan:
(WORDS=4, W=28)
1. Add with boundary carry: op_a=0x000007F, op_b=0x0000001, cin=0, sub=0 → sum=0x0000080, cout=0, ovf=0; out_valid exactly 4 edges after accept.
2. Full carry ripple: op_a=0xFFFFFFF, op_b=0x0000001, cin=0 → sum=0x0000000, cout=1, ovf=0. Repeat with op_b=0, cin=1 → same result.
3. Subtract: sub=1, op_a=0x0000005, op_b=0x0000007, cin=1 (ignored) → sum=0xFFFFFFE, cout=0, ovf=0. Repeat with op_a=7, op_b=5 → sum=0x0000002, cout=1.
4. Signed overflow: op_a=0x7FFFFFF, op_b=0x0000001, sub=0 → sum=0x8000000, ovf=1, cout=0.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid and pulse in_valid with new operands → sum, cout, ovf stable; in_ready=0; new op not taken. Then raise out_ready → IDLE on the next edge, and next op accepted one edge later.
6. Reset mid-RUN: assert rst at idx=2 → immediately out_valid=0, sum=0, busy=0. After deassert in_ready=1, and a new op completes correctly.
